// File: rtl/tut4_verilog_sort_minmax_sorter_pipe.sv
// Three-stage pipelined min/max sorting network for four elements with valid/ready flow control.
// Optional completed-output counter enabled by defining TUT4_VERILOG_SORT_MINMAX_SORTER_PIPE_COUNT_EN.
module tut4_verilog_sort_minmax_sorter_pipe #(
    parameter int p_nbits  = 8,
    parameter int p_signed = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic               in_dir,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic [p_nbits-1:0] in2,
    input  logic [p_nbits-1:0] in3,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out0,
    output logic [p_nbits-1:0] out1,
    output logic [p_nbits-1:0] out2,
    output logic [p_nbits-1:0] out3,
    output logic [15:0]        out_count
);

    typedef logic [3:0][p_nbits-1:0] quad_t;
    typedef logic [1:0][p_nbits-1:0] pair_t;

    localparam quad_t QUAD_ZERO = {(4*p_nbits){1'b0}};

    function automatic logic lt(input logic [p_nbits-1:0] a, input logic [p_nbits-1:0] b);
        if (p_signed != 0) begin
            return $signed(a) < $signed(b);
        end else begin
            return a < b;
        end
    endfunction

    // Returns [0] = lower slot, [1] = upper slot; descending swaps min and max.
    function automatic pair_t ce(input logic [p_nbits-1:0] a, input logic [p_nbits-1:0] b,
                                 input logic dir);
        pair_t              r;
        logic [p_nbits-1:0] mn;
        logic [p_nbits-1:0] mx;
        if (lt(b, a)) begin
            mn = b;
            mx = a;
        end else begin
            mn = a;
            mx = b;
        end
        if (dir) begin
            r[0] = mx;
            r[1] = mn;
        end else begin
            r[0] = mn;
            r[1] = mx;
        end
        return r;
    endfunction

    logic  val1_q, val2_q, val3_q;
    logic  val1_d, val2_d, val3_d;
    logic  dir1_q, dir2_q, dir3_q;
    logic  dir1_d, dir2_d, dir3_d;
    quad_t dat1_q, dat2_q, dat3_q;
    quad_t dat1_d, dat2_d, dat3_d;

    logic  rdy1_s, rdy2_s, rdy3_s;
    quad_t lvl1_s, lvl2_s, lvl3_s;
    pair_t pa_s, pb_s;

    // Backpressure ripples combinationally from the output toward the input.
    always_comb begin
        rdy3_s = !val3_q || out_rdy;
        rdy2_s = !val2_q || rdy3_s;
        rdy1_s = !val1_q || rdy2_s;
    end

    assign in_rdy = rdy1_s;

    // Compare-exchange network: one level per pipeline stage.
    always_comb begin
        lvl1_s      = QUAD_ZERO;
        lvl1_s[1:0] = ce(in0, in1, in_dir);
        lvl1_s[3:2] = ce(in2, in3, in_dir);

        pa_s        = ce(dat1_q[0], dat1_q[2], dir1_q);
        pb_s        = ce(dat1_q[1], dat1_q[3], dir1_q);
        lvl2_s      = QUAD_ZERO;
        lvl2_s[0]   = pa_s[0];
        lvl2_s[2]   = pa_s[1];
        lvl2_s[1]   = pb_s[0];
        lvl2_s[3]   = pb_s[1];

        lvl3_s      = dat2_q;
        lvl3_s[2:1] = ce(dat2_q[1], dat2_q[2], dir2_q);
    end

    // Stage next-state: load from upstream when ready, otherwise hold.
    always_comb begin
        val1_d = val1_q;
        dir1_d = dir1_q;
        dat1_d = dat1_q;
        val2_d = val2_q;
        dir2_d = dir2_q;
        dat2_d = dat2_q;
        val3_d = val3_q;
        dir3_d = dir3_q;
        dat3_d = dat3_q;
        if (rdy1_s) begin
            val1_d = in_val;
            dir1_d = in_dir;
            dat1_d = lvl1_s;
        end else begin
            val1_d = val1_q;
        end
        if (rdy2_s) begin
            val2_d = val1_q;
            dir2_d = dir1_q;
            dat2_d = lvl2_s;
        end else begin
            val2_d = val2_q;
        end
        if (rdy3_s) begin
            val3_d = val2_q;
            dir3_d = dir2_q;
            dat3_d = lvl3_s;
        end else begin
            val3_d = val3_q;
        end
    end

    // Pipeline stage registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val1_q <= 1'b0;
            val2_q <= 1'b0;
            val3_q <= 1'b0;
            dir1_q <= 1'b0;
            dir2_q <= 1'b0;
            dir3_q <= 1'b0;
            dat1_q <= QUAD_ZERO;
            dat2_q <= QUAD_ZERO;
            dat3_q <= QUAD_ZERO;
        end else begin
            val1_q <= val1_d;
            val2_q <= val2_d;
            val3_q <= val3_d;
            dir1_q <= dir1_d;
            dir2_q <= dir2_d;
            dir3_q <= dir3_d;
            dat1_q <= dat1_d;
            dat2_q <= dat2_d;
            dat3_q <= dat3_d;
        end
    end

    assign out_val = val3_q;
    assign out0    = dat3_q[0];
    assign out1    = dat3_q[1];
    assign out2    = dat3_q[2];
    assign out3    = dat3_q[3];

`ifdef TUT4_VERILOG_SORT_MINMAX_SORTER_PIPE_COUNT_EN
    logic [15:0] count_q;
    logic [15:0] count_d;

    // Count output handshakes; 16-bit arithmetic wraps naturally.
    always_comb begin
        count_d = count_q;
        if (val3_q && out_rdy) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Output counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;
`else
    assign out_count = 16'd0;
`endif

endmodule
